// File: rtl/keypad_scan.sv
// Matrix keypad scanner: walks three active-low columns, debounces whole frames, emits one code per press.
// Latency: the code appears the cycle after the DEBOUNCE-th consecutive matching frame ends.
// Backpressure: none; key_valid is a single-cycle strobe that the consumer must take when it appears.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [6:0] keyb,
    output logic       key_valid
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [6:0]    IDLE_CODE = 7'b1111111;

    typedef enum logic [1:0] {FR_NONE, FR_KEY, FR_MULTI} frame_t;
    typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD} state_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] div_cnt;
    logic [1:0]    slot;
    logic          sample;
    logic          frame_end;
    logic          slot_idle;
    logic          slot_single;
    frame_t        acc_kind;
    frame_t        prev_kind;
    frame_t        cur_kind;
    logic [6:0]    acc_code;
    logic [6:0]    cur_code;
    state_t        state;
    state_t        state_nx;
    logic [6:0]    cand;
    logic [6:0]    cand_nx;
    logic [6:0]    keyb_nx;
    logic          valid_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] rel;
    logic [CW-1:0] rel_nx;
    logic [CW-1:0] rel_inc;

    // Two-flop synchronizer for the asynchronous row pins; idles high like the pull-ups.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    assign sample    = (div_cnt == DIV_LAST);
    assign frame_end = sample && (slot == 2'd2);

    // Slot timer: rows are sampled on the last cycle of a slot and the column moves on that same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            slot    <= 2'd0;
        end else if (sample) begin
            div_cnt <= '0;
            slot    <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // Column drive decoded from the slot index.
    always_comb begin
        col_out = 3'b011;
        case (slot)
            2'd1:    col_out = 3'b101;
            2'd2:    col_out = 3'b110;
            default: col_out = 3'b011;
        endcase
    end

    // Per-slot row classification: all high, exactly one low, or anything else.
    always_comb begin
        slot_idle   = (row_sync == 4'b1111);
        slot_single = 1'b0;
        case (row_sync)
            4'b0111, 4'b1011, 4'b1101, 4'b1110: slot_single = 1'b1;
            default:                            slot_single = 1'b0;
        endcase
    end

    // Fold this slot into the running frame result; slot 0 starts a fresh frame.
    always_comb begin
        prev_kind = (slot == 2'd0) ? FR_NONE : acc_kind;
        cur_kind  = prev_kind;
        cur_code  = acc_code;
        if (!slot_idle) begin
            if (slot_single && (prev_kind == FR_NONE)) begin
                cur_kind = FR_KEY;
                cur_code = {col_out, row_sync};
            end else begin
                cur_kind = FR_MULTI;
            end
        end
    end

    // Frame accumulator, updated only at sampling points.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_kind <= FR_NONE;
            acc_code <= IDLE_CODE;
        end else if (sample) begin
            acc_kind <= cur_kind;
            acc_code <= cur_code;
        end
    end

    // Saturating increments so the counters never wrap.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign rel_inc = (rel == CNT_MAX) ? rel : rel + CNT_ONE;

    // Debounce next-state: press needs DEBOUNCE matching frames, release needs DEBOUNCE empty frames.
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        rel_nx   = rel;
        keyb_nx  = IDLE_CODE;
        valid_nx = 1'b0;
        if (frame_end) begin
            case (state)
                S_IDLE: begin
                    if (cur_kind == FR_KEY) begin
                        cand_nx = cur_code;
                        cnt_nx  = CNT_ONE;
                        rel_nx  = CNT_ZERO;
                        if (CNT_ONE == CNT_MAX) begin
                            keyb_nx  = cur_code;
                            valid_nx = 1'b1;
                            state_nx = S_HELD;
                        end else begin
                            state_nx = S_DEB;
                        end
                    end
                end
                S_DEB: begin
                    if (cur_kind == FR_KEY) begin
                        if (cur_code == cand) begin
                            cnt_nx = cnt_inc;
                            if (cnt_inc == CNT_MAX) begin
                                keyb_nx  = cand;
                                valid_nx = 1'b1;
                                rel_nx   = CNT_ZERO;
                                state_nx = S_HELD;
                            end
                        end else begin
                            cand_nx = cur_code;
                            cnt_nx  = CNT_ONE;
                        end
                    end else begin
                        cnt_nx   = CNT_ZERO;
                        state_nx = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (cur_kind == FR_NONE) begin
                        rel_nx = rel_inc;
                        if (rel_inc == CNT_MAX) begin
                            rel_nx   = CNT_ZERO;
                            cnt_nx   = CNT_ZERO;
                            state_nx = S_IDLE;
                        end
                    end else begin
                        rel_nx = CNT_ZERO;
                    end
                end
                default: begin
                    cnt_nx   = CNT_ZERO;
                    rel_nx   = CNT_ZERO;
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Debounce state and registered outputs; reset discards any pending candidate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cand      <= IDLE_CODE;
            cnt       <= CNT_ZERO;
            rel       <= CNT_ZERO;
            keyb      <= IDLE_CODE;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            rel       <= rel_nx;
            keyb      <= keyb_nx;
            key_valid <= valid_nx;
        end
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad scanner that produces the 7-bit `keyb` key codes consumed by the guessing-number game controller. It drives the three keypad columns active-low one at a time and reads the four row lines. It debounces each press and emits every accepted press as a single-cycle code on `keyb`, holding the idle code `7'b1111111` at all other times. It sits between the board keypad pins and the game FSM, so a held key can never be seen twice by the FSM.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per column slot; must be ≥ 4.
- `DEBOUNCE`, default 4: number of consecutive identical frames required to accept a press or a release; must be ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `row_in`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_out`  out  3  keypad column drive, active-low one-hot.
- `keyb`  out  7  key code `{col_out, row}`; `7'b1111111` when no event.
- `key_valid`  out  1  high in exactly the cycle `keyb` carries a code.

## Operation
- Column map: slot 0 drives `col_out=3'b011` (keys 1,4,7,*), slot 1 drives `3'b101` (2,5,8,0), slot 2 drives `3'b110` (3,6,9,#).
- Row map for `row_in`: `0111`=row0 (1,2,3), `1011`=row1, `1101`=row2, `1110`=row3 (*,0,#).
- Resulting codes: 1=`0110111`, 5=`1011011`, 0=`1011110`, *=`0111110`, #=`1101110`.
- `row_in` passes through a 2-FF synchronizer before use.
- Divider counts 0..SCAN_DIV-1. Rows are sampled on the last cycle of each slot, and the column advances on the same edge (2→0 wraps).
- A frame is three slots, 3×SCAN_DIV cycles. Frame result is one of:
  - KEY(code): exactly one low row in exactly one slot.
  - NONE: no low rows.
  - MULTI: any other pattern.
- Debounce FSM, evaluated once per frame end:
  - IDLE: KEY(c) → cand=c, cnt=1; if DEBOUNCE=1, emit c and go HELD, otherwise go DEB. NONE or MULTI → stay in IDLE.
  - DEB: KEY(cand) → cnt+1; when cnt reaches DEBOUNCE, emit cand and go HELD. KEY(other) → cand=other, cnt=1. NONE or MULTI → IDLE, cnt=0.
  - HELD: NONE → rel+1; when rel reaches DEBOUNCE, go IDLE. KEY or MULTI → rel=0 and stay; nothing is emitted.
- Emit: `keyb`=cand and `key_valid`=1 for one cycle, then back to `7'b1111111` and 0.
- Counters are sized to `$clog2(DEBOUNCE+1)` and saturate; they never wrap.

## Timing
- Reset values: `col_out=3'b011`, `keyb=7'b1111111`, `key_valid=0`, FSM=IDLE, all counters 0, synchronizer flops all 1.
- Reset is asynchronous and takes effect immediately, including mid-frame and mid-DEB; a pending candidate is discarded.
- Sampling point: the last cycle of each slot. The synchronizer delay of 2 cycles is less than SCAN_DIV, so rows have settled after the column change.
- Press latency: the emit pulse appears in the cycle after the end of the DEBOUNCE-th consecutive KEY frame. Worst case from stable press is (DEBOUNCE+1)×3×SCAN_DIV+3 cycles.
- Minimum press-to-press spacing: DEBOUNCE NONE frames are required between two accepted presses of any keys.
- At most one emit occurs per frame. `key_valid` is never high on two consecutive cycles.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=2, giving 12-cycle frames.
- Reset: assert `rst`=0 mid-slot → `col_out=011`, `keyb=1111111`, `key_valid=0` immediately. Release reset → `col_out` sequence 011,101,110 with 4 cycles each, repeating.
- Single press: model key '5' (row1 low while `col_out=101`) held for 30 frames → exactly one pulse of `keyb=1011011` with `key_valid=1`, within 39 cycles of the press; `keyb=1111111` for the rest of the hold.
- Bounce: toggle key '3' every 5 cycles for 40 cycles, then release → no pulse. Then hold '3' stable → one pulse `1100111`.
- Two keys: hold '1' and '2' together for 10 frames → no pulse. Release '2' and keep '1' → one pulse `0110111` after 2 frames.
- Repeat/release: press '#' → pulse `1101110`. Release for 1 frame, then press again → no second pulse. Release for ≥2 frames, then press → second pulse `1101110`.
- Reset mid-debounce: press '0', assert reset after the first KEY frame, release reset with '0' still held → no pulse until 2 full frames after reset release, then exactly one `1011110`.
